// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the multi-cycle chunked adder.
//   - state_e       : FSM state encoding (Idle / Run / Done)
//   - calc_nchunk   : number of CHUNK-bit slices in a WIDTH-bit operand
//   - calc_idx_w    : width of the chunk index register (never below 1 bit)
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 12;
  localparam int unsigned DefaultChunk = 4;

  function automatic int unsigned calc_nchunk(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int unsigned calc_idx_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// Ports:
//   i_a, i_b  : CHUNK-bit addends
//   i_cin     : carry into bit 0
//   o_sum     : CHUNK-bit sum
//   o_cout    : carry out of the top bit
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    logic w_p;
    assign w_p         = i_a[gi] ^ i_b[gi];
    assign o_sum[gi]   = w_p ^ w_c[gi];
    assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & w_p);
  end

  assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits of WIDTH-bit operands per
// clock with a registered carry between chunks, behind a start/busy/done
// handshake.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : request, accepted only in Idle or Done
//   sub    : 0 = a + b, 1 = a - b (sampled with start)
//   a, b   : WIDTH-bit operands (sampled with start)
//   busy   : high while chunks are being processed
//   done   : one-cycle result-valid pulse
//   sum    : WIDTH+1-bit result, sum[WIDTH] = carry-out (1 = no borrow on sub)
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  // WIDTH must be a non-zero multiple of CHUNK; no runtime check is made.
  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = calc_idx_w(NCHUNK);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH:0]   r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_s_chunk;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Slice selection and merge of the current chunk into the partial result.
  always_comb begin
    w_a_chunk  = r_a[r_idx * CHUNK +: CHUNK];
    w_b_chunk  = r_b[r_idx * CHUNK +: CHUNK];
    w_res_next = r_res;
    w_res_next[r_idx * CHUNK +: CHUNK] = w_s_chunk;
    w_last     = (r_idx == IDX_W'(NCHUNK - 1));
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_s_chunk),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b here, the +1 rides in on carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          if (w_last) begin
            // Only the completed result is ever published on sum.
            r_sum   <= {w_cout, w_res_next};
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;

endmodule
